decoder_scan_reg: RTL and testbench

Parametrised, registered N-to-2^N one-hot decoder with built-in scan sequencer. It is the successor of the team's combinational 2-to-4 decoder. Beyond direct decode, it walks the one-hot output up or down through all lines with a programmable dwell time and flags each wrap-around. It is used for row/digit scanning and strobe generation in the board-level demos.

---
 rtl/decoder_scan_reg.sv | 106 ++++++++++
 tb/tb_decoder_scan_reg.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/decoder_scan_reg.sv
// Registered N-to-2^N one-hot decoder with an up/down scan sequencer.
// Scan steps are held for a live-sampled dwell count; wrap pulses mark the cycle the wrapped line appears.
module decoder_scan_reg #(
  parameter int N  = 2,
  parameter int DW = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          mode,
  input  logic                en,
  input  logic [N-1:0]        sel,
  input  logic [DW-1:0]       dwell,
  output logic [(1<<N)-1:0]   out,
  output logic [N-1:0]        idx,
  output logic                valid,
  output logic                wrap
);
  localparam int L = 1 << N;
  localparam logic [L-1:0] ONE = L'(1);

  typedef enum logic [1:0] {
    OFF       = 2'b00,
    DIRECT    = 2'b01,
    SCAN_UP   = 2'b10,
    SCAN_DOWN = 2'b11
  } state_t;

  state_t        state_q, state_d;
  logic [L-1:0]  out_q, out_d;
  logic [N-1:0]  idx_q, idx_d;
  logic          valid_q, valid_d;
  logic          wrap_q, wrap_d;
  logic [DW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] last_cnt;
  logic          entry;

  // dwell of 0 behaves like 1, so the terminal count is 0 in both cases
  assign last_cnt = (dwell == '0) ? '0 : dwell - 1'b1;

  always_comb begin
    state_d = state_t'(mode);
    idx_d   = idx_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    wrap_d  = 1'b0;
    entry   = (state_d != state_q);
    case (state_d)
      OFF: begin
        valid_d = 1'b0;
        cnt_d   = '0;
      end
      DIRECT: begin
        cnt_d = '0;
        if (en) begin
          idx_d   = sel;
          valid_d = 1'b1;
        end
      end
      default: begin
        if (entry) begin
          idx_d   = sel;
          valid_d = 1'b1;
          cnt_d   = '0;
        end else if (en) begin
          // >= so a live dwell drop below the running count steps at once
          if (cnt_q >= last_cnt) begin
            cnt_d = '0;
            if (state_d == SCAN_UP) begin
              idx_d  = idx_q + 1'b1;
              wrap_d = (idx_q == {N{1'b1}});
            end else begin
              idx_d  = idx_q - 1'b1;
              wrap_d = (idx_q == '0);
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
    endcase
    out_d = valid_d ? (ONE << idx_d) : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= OFF;
      out_q   <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out   = out_q;
  assign idx   = idx_q;
  assign valid = valid_q;
  assign wrap  = wrap_q;
endmodule

// File: tb/tb_decoder_scan_reg.sv
// Bench: directed vector table and hand sequences on an N=2 decoder, then
// randomized traffic on an N=3 decoder compared against an arithmetic reference.
module tb_decoder_scan_reg;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // N=2 instance
  logic       rst_n2, en2, valid2, wrap2;
  logic [1:0] mode2, sel2, idx2;
  logic [3:0] dwell2, out2;

  decoder_scan_reg #(.N(2), .DW(4)) u_dut2 (
    .clk(clk), .rst_n(rst_n2), .mode(mode2), .en(en2), .sel(sel2), .dwell(dwell2),
    .out(out2), .idx(idx2), .valid(valid2), .wrap(wrap2)
  );

  // N=3 instance
  logic       rst_n3, en3, valid3, wrap3;
  logic [1:0] mode3;
  logic [2:0] sel3, idx3;
  logic [3:0] dwell3;
  logic [7:0] out3;

  decoder_scan_reg #(.N(3), .DW(4)) u_dut3 (
    .clk(clk), .rst_n(rst_n3), .mode(mode3), .en(en3), .sel(sel3), .dwell(dwell3),
    .out(out3), .idx(idx3), .valid(valid3), .wrap(wrap3)
  );

  typedef struct {
    logic       rst_n;
    logic [1:0] mode;
    logic       en;
    logic [1:0] sel;
    logic [3:0] dwell;
    logic [3:0] e_out;
    int         e_idx;
    logic       e_valid;
    logic       e_wrap;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic r, logic [1:0] m, logic e, logic [1:0] s, logic [3:0] d,
                              logic [3:0] eo, int ei, logic ev, logic ew);
    vec_t v;
    v.rst_n = r; v.mode = m; v.en = e; v.sel = s; v.dwell = d;
    v.e_out = eo; v.e_idx = ei; v.e_valid = ev; v.e_wrap = ew;
    return v;
  endfunction

  task automatic chk(input string name, input int step, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s step %0d: got %0d expected %0d", name, step, act, exp);
    end
  endtask

  task automatic apply2(input vec_t v, input int step);
    rst_n2 = v.rst_n; mode2 = v.mode; en2 = v.en; sel2 = v.sel; dwell2 = v.dwell;
    @(posedge clk); #1;
    chk("out", step, int'(out2), int'(v.e_out));
    chk("idx", step, int'(idx2), v.e_idx);
    chk("valid", step, int'(valid2), int'(v.e_valid));
    chk("wrap", step, int'(wrap2), int'(v.e_wrap));
  endtask

  // reference state for the N=3 random run
  int m_state, m_idx, m_valid, m_cnt, m_wrap;

  task automatic model_step(input logic r, input logic [1:0] m, input logic e,
                            input int s, input int d);
    int dd;
    if (!r) begin
      m_state = 0; m_idx = 0; m_valid = 0; m_cnt = 0; m_wrap = 0;
      return;
    end
    m_wrap = 0;
    if (m == 2'b00) begin
      m_valid = 0; m_cnt = 0;
    end else if (m == 2'b01) begin
      m_cnt = 0;
      if (e) begin m_idx = s; m_valid = 1; end
    end else if (int'(m) != m_state) begin
      m_idx = s; m_valid = 1; m_cnt = 0;
    end else if (e) begin
      dd = (d == 0) ? 1 : d;
      if (m_cnt + 1 >= dd) begin
        m_cnt = 0;
        if (m == 2'b10) begin
          m_wrap = (m_idx == 7) ? 1 : 0;
          m_idx = (m_idx + 1) % 8;
        end else begin
          m_wrap = (m_idx == 0) ? 1 : 0;
          m_idx = (m_idx + 7) % 8;
        end
      end else begin
        m_cnt++;
      end
    end
    m_state = int'(m);
  endtask

  initial begin
    int n;
    rst_n2 = 0; mode2 = 0; en2 = 0; sel2 = 0; dwell2 = 0;
    rst_n3 = 0; mode3 = 0; en3 = 0; sel3 = 0; dwell3 = 0;

    // reset, then direct decode
    tbl.push_back(mk(0, 2'b01, 1, 2, 0, 4'b0000, 0, 0, 0));
    tbl.push_back(mk(0, 2'b01, 1, 2, 0, 4'b0000, 0, 0, 0));
    tbl.push_back(mk(1, 2'b01, 1, 2, 0, 4'b0100, 2, 1, 0));
    tbl.push_back(mk(1, 2'b01, 1, 1, 0, 4'b0010, 1, 1, 0));
    tbl.push_back(mk(1, 2'b01, 1, 3, 0, 4'b1000, 3, 1, 0));
    tbl.push_back(mk(1, 2'b01, 1, 0, 0, 4'b0001, 0, 1, 0));
    // scan up from 2, dwell 3
    begin
      int seq[14] = '{2,2,2,3,3,3,0,0,0,1,1,1,2,2};
      for (int i = 0; i < 14; i++)
        tbl.push_back(mk(1, 2'b10, 1, 2, 3, 4'(1 << seq[i]), seq[i], 1, (i == 6) ? 1'b1 : 1'b0));
    end
    // scan down, dwell 0, en gaps
    tbl.push_back(mk(1, 2'b11, 1, 1, 0, 4'b0010, 1, 1, 0));
    tbl.push_back(mk(1, 2'b11, 1, 1, 0, 4'b0001, 0, 1, 0));
    tbl.push_back(mk(1, 2'b11, 1, 1, 0, 4'b1000, 3, 1, 1));
    tbl.push_back(mk(1, 2'b11, 0, 1, 0, 4'b1000, 3, 1, 0));
    tbl.push_back(mk(1, 2'b11, 0, 1, 0, 4'b1000, 3, 1, 0));
    tbl.push_back(mk(1, 2'b11, 1, 1, 0, 4'b0100, 2, 1, 0));
    // scan up entry at 3 with en=0, then OFF holds idx
    tbl.push_back(mk(1, 2'b10, 0, 3, 1, 4'b1000, 3, 1, 0));
    tbl.push_back(mk(1, 2'b00, 1, 1, 1, 4'b0000, 3, 0, 0));
    tbl.push_back(mk(1, 2'b00, 1, 2, 1, 4'b0000, 3, 0, 0));
    // DIRECT entry with en=0 from OFF leaves outputs dark
    tbl.push_back(mk(1, 2'b01, 0, 1, 1, 4'b0000, 3, 0, 0));

    foreach (tbl[i]) apply2(tbl[i], i);

    // mid-dwell direction switch discards the partial count
    n = 100;
    apply2(mk(1, 2'b10, 1, 1, 4, 4'b0010, 1, 1, 0), n++);
    apply2(mk(1, 2'b10, 1, 0, 4, 4'b0010, 1, 1, 0), n++);
    apply2(mk(1, 2'b11, 1, 3, 4, 4'b1000, 3, 1, 0), n++);
    apply2(mk(1, 2'b11, 1, 0, 4, 4'b1000, 3, 1, 0), n++);
    apply2(mk(1, 2'b11, 1, 0, 4, 4'b1000, 3, 1, 0), n++);
    apply2(mk(1, 2'b11, 1, 0, 4, 4'b1000, 3, 1, 0), n++);
    apply2(mk(1, 2'b11, 1, 0, 4, 4'b0100, 2, 1, 0), n++);
    // live dwell drop below running count steps on the next enabled edge
    apply2(mk(1, 2'b11, 1, 0, 4, 4'b0100, 2, 1, 0), n++);
    apply2(mk(1, 2'b11, 1, 0, 4, 4'b0100, 2, 1, 0), n++);
    apply2(mk(1, 2'b11, 1, 0, 1, 4'b0010, 1, 1, 0), n++);
    // mid-scan reset, then re-entry from sel
    apply2(mk(0, 2'b11, 1, 2, 1, 4'b0000, 0, 0, 0), n++);
    apply2(mk(1, 2'b11, 0, 2, 1, 4'b0100, 2, 1, 0), n++);

    // randomized N=3 run against the reference
    model_step(0, 0, 0, 0, 0);
    for (int c = 0; c < 2000; c++) begin
      logic r, e;
      logic [1:0] m;
      logic [2:0] s;
      logic [3:0] d;
      r = (c < 2) ? 1'b0 : (($urandom_range(0, 63) != 0) ? 1'b1 : 1'b0);
      m = ($urandom_range(0, 15) == 0 || c == 2) ? 2'($urandom_range(0, 3)) : mode3;
      e = ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0;
      s = 3'($urandom_range(0, 7));
      d = 4'($urandom_range(0, 5));
      rst_n3 = r; mode3 = m; en3 = e; sel3 = s; dwell3 = d;
      @(posedge clk); #1;
      model_step(r, m, e, int'(s), int'(d));
      chk("rnd_idx", c, int'(idx3), m_idx);
      chk("rnd_valid", c, int'(valid3), m_valid);
      chk("rnd_wrap", c, int'(wrap3), m_wrap);
      chk("rnd_out", c, int'(out3), m_valid ? (1 << m_idx) : 0);
      chk("rnd_onehot", c, ($countones(out3) <= 1) ? 1 : 0, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
